// File: rtl/count_adjust_field.sv
// ============================================================================
// Module      : count_adjust_field
// Description : Wrapping count field with a dynamic upper limit and
//               button adjust with press, hold-delay and auto-repeat.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module count_adjust_field #(
    parameter int WIDTH     = 5,
    parameter int MIN_VAL   = 1,
    parameter int MAX_VAL   = 31,
    parameter int HOLD_CYC  = 4,
    parameter int RPT_CYC   = 2,
    parameter int ADJ_CARRY = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             carry_in,
    input  logic             adj_en,
    input  logic             adj_up,
    input  logic             adj_down,
    input  logic [WIDTH-1:0] max_dyn,
    output logic [WIDTH-1:0] val,
    output logic             carry_out,
    output logic             borrow_out
);

    localparam int CNT_MAX = (HOLD_CYC > RPT_CYC) ? HOLD_CYC : RPT_CYC;
    localparam int CW      = $clog2(CNT_MAX);

    localparam logic [WIDTH-1:0] MIN_V     = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_V     = WIDTH'(MAX_VAL);
    localparam logic [CW-1:0]    HOLD_LAST = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0]    RPT_LAST  = CW'(RPT_CYC - 1);
    localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
    localparam logic             CARRY_EN  = (ADJ_CARRY != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic             dir, dir_nx;
    logic [WIDTH-1:0] val_nx;
    logic             carry_nx, borrow_nx;
    logic             prev_up, prev_dn;

    logic [WIDTH-1:0] emax;
    logic             up_act, dn_act;
    logic             up_edge, dn_edge;
    logic             held;
    logic             do_step;

    // A limit below the legal floor is treated as "no dynamic limit".
    always_comb begin
        if (max_dyn < MIN_V) begin
            emax = MAX_V;
        end else if (max_dyn < MAX_V) begin
            emax = max_dyn;
        end else begin
            emax = MAX_V;
        end
    end

    assign up_act  = adj_up & ~adj_down;
    assign dn_act  = adj_down & ~adj_up;
    assign up_edge = up_act & ~prev_up;
    assign dn_edge = dn_act & ~prev_dn;
    assign held    = dir ? up_act : dn_act;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            dir        <= 1'b0;
            val        <= MIN_V;
            carry_out  <= 1'b0;
            borrow_out <= 1'b0;
            prev_up    <= 1'b1;
            prev_dn    <= 1'b1;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            dir        <= dir_nx;
            val        <= val_nx;
            carry_out  <= carry_nx;
            borrow_out <= borrow_nx;
            prev_up    <= adj_up;
            prev_dn    <= adj_down;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        dir_nx    = dir;
        val_nx    = val;
        carry_nx  = 1'b0;
        borrow_nx = 1'b0;
        do_step   = 1'b0;

        if (val > emax) begin
            val_nx   = emax;
            state_nx = IDLE;
            cnt_nx   = '0;
        end else if (val < MIN_V) begin
            val_nx   = MIN_V;
            state_nx = IDLE;
            cnt_nx   = '0;
        end else if (!adj_en) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            if (carry_in) begin
                if (val == emax) begin
                    val_nx   = MIN_V;
                    carry_nx = 1'b1;
                end else begin
                    val_nx = val + 1'b1;
                end
            end
        end else begin
            case (state)
                IDLE: begin
                    if (up_edge || dn_edge) begin
                        do_step  = 1'b1;
                        dir_nx   = up_edge;
                        state_nx = DELAY;
                        cnt_nx   = '0;
                    end
                end
                DELAY: begin
                    if (held) begin
                        if (cnt == HOLD_LAST) begin
                            do_step  = 1'b1;
                            state_nx = REPEAT;
                            cnt_nx   = '0;
                        end else begin
                            cnt_nx = cnt + CNT_ONE;
                        end
                    end else begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end
                end
                REPEAT: begin
                    if (held) begin
                        if (cnt == RPT_LAST) begin
                            do_step = 1'b1;
                            cnt_nx  = '0;
                        end else begin
                            cnt_nx = cnt + CNT_ONE;
                        end
                    end else begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            endcase

            // Direction is latched at the press, so repeats follow dir_nx.
            if (do_step) begin
                if (dir_nx) begin
                    if (val == emax) begin
                        val_nx   = MIN_V;
                        carry_nx = CARRY_EN;
                    end else begin
                        val_nx = val + 1'b1;
                    end
                end else begin
                    if (val == MIN_V) begin
                        val_nx    = emax;
                        borrow_nx = CARRY_EN;
                    end else begin
                        val_nx = val - 1'b1;
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_count_adjust_field.sv
// ============================================================================
// Module      : tb_count_adjust_field
// Description : Scoreboard bench for count_adjust_field, ADJ_CARRY=0 and 1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_count_adjust_field;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       carry_in = 1'b0;
    logic       adj_en = 1'b0;
    logic       adj_up = 1'b0;
    logic       adj_down = 1'b0;
    logic [4:0] max_dyn = 5'd31;

    logic [4:0] val0, val1;
    logic       co0, bo0, co1, bo1;
    logic [13:0] obs;

    int total = 0;
    int bad   = 0;
    logic [13:0] q[$];

    int m_val = 0;
    int m_btn = 0;
    int m_age = 0;
    bit m_pu  = 1'b1;
    bit m_pd  = 1'b1;

    always #5 clk = ~clk;

    count_adjust_field #(.ADJ_CARRY(0)) dut0 (
        .clk(clk), .rst(rst), .carry_in(carry_in), .adj_en(adj_en),
        .adj_up(adj_up), .adj_down(adj_down), .max_dyn(max_dyn),
        .val(val0), .carry_out(co0), .borrow_out(bo0)
    );

    count_adjust_field #(.ADJ_CARRY(1)) dut1 (
        .clk(clk), .rst(rst), .carry_in(carry_in), .adj_en(adj_en),
        .adj_up(adj_up), .adj_down(adj_down), .max_dyn(max_dyn),
        .val(val1), .carry_out(co1), .borrow_out(bo1)
    );

    assign obs = {val0, co0, bo0, val1, co1, bo1};

    // Reference model: steps follow the age of the current hold
    // (age 0, HOLD, HOLD+RPT, ...), then one clock edge is applied.
    task automatic tick();
        int  emax;
        int  cur;
        bit  do_step;
        bit  cnt_c;
        bit  adj_c;
        bit  adj_b;
        cnt_c = 1'b0;
        adj_c = 1'b0;
        adj_b = 1'b0;
        if (rst) begin
            m_val = 1; m_btn = 0; m_age = 0; m_pu = 1'b1; m_pd = 1'b1;
        end else begin
            emax = (max_dyn < 5'd1) ? 31 : ((int'(max_dyn) < 31) ? int'(max_dyn) : 31);
            if (m_val > emax) begin
                m_val = emax; m_btn = 0;
            end else if (m_val < 1) begin
                m_val = 1; m_btn = 0;
            end else if (!adj_en) begin
                m_btn = 0;
                if (carry_in) begin
                    if (m_val == emax) begin m_val = 1; cnt_c = 1'b1; end
                    else m_val = m_val + 1;
                end
            end else begin
                cur = (adj_up && !adj_down) ? 1 : ((adj_down && !adj_up) ? 2 : 0);
                do_step = 1'b0;
                if (m_btn != 0) begin
                    if (cur == m_btn) begin
                        m_age = m_age + 1;
                        if (m_age == 4 || (m_age > 4 && ((m_age - 4) % 2) == 0)) do_step = 1'b1;
                    end else begin
                        m_btn = 0;
                    end
                end else if ((cur == 1 && !m_pu) || (cur == 2 && !m_pd)) begin
                    m_btn = cur; m_age = 0; do_step = 1'b1;
                end
                if (do_step) begin
                    if (m_btn == 1) begin
                        if (m_val == emax) begin m_val = 1; adj_c = 1'b1; end
                        else m_val = m_val + 1;
                    end else begin
                        if (m_val == 1) begin m_val = emax; adj_b = 1'b1; end
                        else m_val = m_val - 1;
                    end
                end
            end
            m_pu = adj_up;
            m_pd = adj_down;
        end
        q.push_back({5'(m_val), cnt_c, 1'b0, 5'(m_val), cnt_c | adj_c, adj_b});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [13:0] exp;
        rst = 1'b1; adj_en = 1'b1; adj_up = 1'b1; adj_down = 1'b0; carry_in = 1'b0;
        repeat (2) tick();
        q.delete();
        total++;
        if (obs !== {5'd1, 2'b00, 5'd1, 2'b00}) begin
            bad++; $display("FAIL reset_state got=%h want=%h", obs, {5'd1, 2'b00, 5'd1, 2'b00});
        end
        rst = 1'b0;
        repeat (4) begin
            tick(); exp = q.pop_front(); total++;
            if (obs !== exp) begin bad++; $display("FAIL reset_hold got=%h want=%h", obs, exp); end
        end
        total++;
        if (val0 !== 5'd1) begin bad++; $display("FAIL reset_no_step got=%0d want=1", val0); end
        adj_up = 1'b0;
        tick(); exp = q.pop_front(); total++;
        if (obs !== exp) begin bad++; $display("FAIL reset_release got=%h want=%h", obs, exp); end
    endtask

    task automatic test_reset_override();
        logic [13:0] exp;
        adj_en = 1'b1; adj_up = 1'b1;
        repeat (7) begin
            tick(); exp = q.pop_front(); total++;
            if (obs !== exp) begin bad++; $display("FAIL ovr_hold got=%h want=%h", obs, exp); end
        end
        rst = 1'b1;
        tick(); exp = q.pop_front(); total++;
        if (obs !== exp) begin bad++; $display("FAIL ovr_reset got=%h want=%h", obs, exp); end
        rst = 1'b0;
        repeat (6) begin
            tick(); exp = q.pop_front(); total++;
            if (obs !== exp) begin bad++; $display("FAIL ovr_after got=%h want=%h", obs, exp); end
        end
        total++;
        if (val0 !== 5'd1) begin bad++; $display("FAIL ovr_val got=%0d want=1", val0); end
        adj_up = 1'b0; adj_en = 1'b0;
        tick(); void'(q.pop_front());
    endtask

    task automatic test_count_wrap();
        logic [13:0] exp;
        max_dyn = 5'd30; adj_en = 1'b1; adj_down = 1'b1;
        tick(); exp = q.pop_front(); total++;
        if (obs !== exp) begin bad++; $display("FAIL down_wrap got=%h want=%h", obs, exp); end
        total++;
        if ({val0, bo0, val1, bo1} !== {5'd30, 1'b0, 5'd30, 1'b1}) begin
            bad++; $display("FAIL down_wrap_fixed got=%h want=%h", {val0, bo0, val1, bo1}, {5'd30, 1'b0, 5'd30, 1'b1});
        end
        adj_down = 1'b0; adj_en = 1'b0;
        tick(); exp = q.pop_front(); total++;
        if (obs !== exp) begin bad++; $display("FAIL down_release got=%h want=%h", obs, exp); end
        carry_in = 1'b1;
        tick(); exp = q.pop_front(); total++;
        if (obs !== exp || val0 !== 5'd1 || co0 !== 1'b1) begin
            bad++; $display("FAIL count_wrap got=%h want=%h", obs, exp);
        end
        repeat (11) begin
            tick(); exp = q.pop_front(); total++;
            if (obs !== exp) begin bad++; $display("FAIL count_run got=%h want=%h", obs, exp); end
        end
        tick(); exp = q.pop_front(); total++;
        if (obs !== exp || {val0, co0} !== {5'd13, 1'b0}) begin
            bad++; $display("FAIL count_12_13 got=%h want=%h", obs, exp);
        end
        carry_in = 1'b0;
    endtask

    task automatic test_dyn_clamp();
        logic [13:0] exp;
        rst = 1'b1; tick(); void'(q.pop_front()); rst = 1'b0;
        max_dyn = 5'd31; adj_en = 1'b1; adj_down = 1'b0;
        tick(); void'(q.pop_front());
        adj_down = 1'b1;
        tick(); exp = q.pop_front(); total++;
        if (obs !== exp || val0 !== 5'd31) begin bad++; $display("FAIL to_31 got=%h want=%h", obs, exp); end
        adj_down = 1'b0; adj_en = 1'b0;
        tick(); void'(q.pop_front());
        max_dyn = 5'd28; carry_in = 1'b1;
        tick(); exp = q.pop_front(); total++;
        if (obs !== exp || {val0, co0, co1} !== {5'd28, 2'b00}) begin
            bad++; $display("FAIL dyn_clamp got=%h want=%h", obs, exp);
        end
        carry_in = 1'b0;
    endtask

    task automatic test_auto_repeat();
        logic [13:0] exp;
        rst = 1'b1; tick(); void'(q.pop_front()); rst = 1'b0;
        max_dyn = 5'd31; adj_en = 1'b0; carry_in = 1'b1;
        repeat (4) begin
            tick(); exp = q.pop_front(); total++;
            if (obs !== exp) begin bad++; $display("FAIL rpt_setup got=%h want=%h", obs, exp); end
        end
        carry_in = 1'b0; adj_en = 1'b1; adj_up = 1'b1;
        repeat (10) begin
            tick(); exp = q.pop_front(); total++;
            if (obs !== exp) begin bad++; $display("FAIL rpt_step got=%h want=%h", obs, exp); end
        end
        total++;
        if (val0 !== 5'd9) begin bad++; $display("FAIL rpt_final got=%0d want=9", val0); end
        adj_up = 1'b0;
        repeat (3) begin
            tick(); exp = q.pop_front(); total++;
            if (obs !== exp || val0 !== 5'd9) begin bad++; $display("FAIL rpt_release got=%h want=%h", obs, exp); end
        end
    endtask

    task automatic test_both_buttons();
        logic [13:0] exp;
        adj_en = 1'b1; adj_up = 1'b1; adj_down = 1'b1; carry_in = 1'b1;
        repeat (5) begin
            tick(); exp = q.pop_front(); total++;
            if (obs !== exp || val0 !== 5'd9) begin bad++; $display("FAIL both_btn got=%h want=%h", obs, exp); end
        end
        adj_up = 1'b0; adj_down = 1'b0; carry_in = 1'b0;
        tick(); void'(q.pop_front());
    endtask

    task automatic test_up_wrap();
        logic [13:0] exp;
        max_dyn = 5'd3; adj_en = 1'b1;
        tick(); exp = q.pop_front(); total++;
        if (obs !== exp || val0 !== 5'd3) begin bad++; $display("FAIL clamp_3 got=%h want=%h", obs, exp); end
        adj_up = 1'b1;
        tick(); exp = q.pop_front(); total++;
        if (obs !== exp || {val1, co1, co0} !== {5'd1, 2'b10}) begin
            bad++; $display("FAIL up_wrap got=%h want=%h", obs, exp);
        end
        adj_up = 1'b0; max_dyn = 5'd0;
        tick(); void'(q.pop_front());
        adj_down = 1'b1;
        tick(); exp = q.pop_front(); total++;
        if (obs !== exp || val0 !== 5'd31) begin bad++; $display("FAIL dyn_below_min got=%h want=%h", obs, exp); end
        adj_down = 1'b0;
        tick(); void'(q.pop_front());
    endtask

    task automatic test_random();
        logic [13:0] exp;
        for (int i = 0; i < 400; i++) begin
            rst      = ($urandom_range(0, 59) == 0);
            carry_in = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 9) == 0) adj_en = ~adj_en;
            if ($urandom_range(0, 6) == 0) adj_up = ~adj_up;
            if ($urandom_range(0, 8) == 0) adj_down = ~adj_down;
            if ($urandom_range(0, 24) == 0) max_dyn = 5'($urandom_range(0, 31));
            tick(); exp = q.pop_front(); total++;
            if (obs !== exp) begin bad++; $display("FAIL random[%0d] got=%h want=%h", i, obs, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_reset_override();
        test_count_wrap();
        test_dyn_clamp();
        test_auto_repeat();
        test_both_buttons();
        test_up_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/count_adjust_field.md
COUNT_ADJUST_FIELD -- requirements
Module: count_adjust_field

Interface
REQ-001 Parameter WIDTH, default 5: value width in bits.
REQ-002 Parameter MIN_VAL, default 1: lowest legal value.
REQ-003 Parameter MAX_VAL, default 31: static upper limit.
REQ-004 Parameter HOLD_CYC, default 4: edges of continuous hold before auto-repeat (>=2).
REQ-005 Parameter RPT_CYC, default 2: edges per auto-repeat step (>=1).
REQ-006 Parameter ADJ_CARRY, default 0: 1 = adjust wraps also pulse carry_out/borrow_out.
REQ-007 clk  input  1  single clock; all state updates on the rising edge.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 carry_in  input  1  one-cycle increment request from the lower field.
REQ-010 adj_en  input  1  adjust mode; high = buttons active, carry_in ignored.
REQ-011 adj_up  input  1  debounced level, increment button.
REQ-012 adj_down  input  1  debounced level, decrement button.
REQ-013 max_dyn  input  WIDTH  dynamic upper limit, for example days in the current month.
REQ-014 val  output  WIDTH  current value, registered.
REQ-015 carry_out  output  1  one-cycle pulse on upward wrap.
REQ-016 borrow_out  output  1  one-cycle pulse on downward wrap; only possible when ADJ_CARRY=1.

Function
REQ-017 The effective maximum EMAX SHALL be min(max_dyn, MAX_VAL), or MAX_VAL if max_dyn < MIN_VAL.
REQ-018 carry_out and borrow_out SHALL default to 0 every cycle and be asserted for exactly one cycle when they fire.
REQ-019 Range correction has top priority: val > EMAX SHALL load EMAX and val < MIN_VAL SHALL load MIN_VAL; in that cycle there is no step, no pulse, and the FSM goes to IDLE.
REQ-020 Count mode (adj_en=0, carry_in=1): val==EMAX SHALL load MIN_VAL and pulse carry_out; otherwise val SHALL increment by 1.
REQ-021 With adj_en=0, the FSM SHALL be forced to IDLE and the hold counter cleared.
REQ-022 In adjust mode the active button is up_act = adj_up & ~adj_down, or dn_act = adj_down & ~adj_up.
  - Both buttons high, or neither high: no step; FSM goes to IDLE.
REQ-023 Step up: EMAX wraps to MIN_VAL, otherwise +1. Step down: MIN_VAL wraps to EMAX, otherwise -1.
  - carry_out/borrow_out pulse on these wraps only if ADJ_CARRY=1.
REQ-024 Button press edge = active button high while its registered previous sample is low.
  - The previous-sample registers update every cycle.
REQ-025 FSM states: IDLE, DELAY, REPEAT. The hold counter is width clog2(max(HOLD_CYC,RPT_CYC)).
  - IDLE + press edge: step, enter DELAY, cnt=0.
  - DELAY, same button held: if cnt==HOLD_CYC-1, step, enter REPEAT, cnt=0; else cnt+1.
  - REPEAT, held: if cnt==RPT_CYC-1, step, cnt=0; else cnt+1.
  - Release, button change, both pressed, or adj_en low: go to IDLE.
REQ-026 Steps therefore occur at press edge e0, at e0+HOLD_CYC, then every RPT_CYC edges after that.
REQ-027 A change of max_dyn SHALL take effect on the next edge through REQ-019.

Reset
REQ-028 While rst=1 at an edge, the block SHALL load:
  - val=MIN_VAL
  - carry_out=0, borrow_out=0
  - FSM=IDLE, cnt=0
  - both previous-sample registers=1
REQ-029 Reset SHALL override all other inputs, including in the middle of DELAY or REPEAT.
REQ-030 A button held through reset SHALL NOT step until it is released and pressed again.

Verification (defaults unless stated)
REQ-031 rst=1 for 2 edges while adj_en=1 and adj_up=1 -> val=1, no pulses; after release, adj_up still high produces no step.
REQ-032 max_dyn=30, val=30, carry_in=1 for one edge -> val=1, carry_out=1 for exactly that cycle; val=12 with carry_in -> 13, no pulse.
REQ-033 val=31, max_dyn changed 31->28 with carry_in=1 in the same cycle -> next val=28, carry_out=0.
REQ-034 adj_en=1, val=5, adj_up held for 10 edges e0..e9 -> steps at e0, e4, e6, e8; final val=9; release -> IDLE, val stays 9.
REQ-035 val=1, max_dyn=30, adj_down press -> val=30 with borrow_out=0; repeat with ADJ_CARRY=1 -> borrow_out=1 for one cycle.
REQ-036 adj_en=1, both buttons high, and carry_in=1 for 5 edges -> val unchanged, no pulses, FSM stays in IDLE.
